// File: rtl/frv_ssm3_pkg.sv
// frv_ssm3_pkg: shared state encoding, op bit indices and SSM3 rotation constants.
package frv_ssm3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT1 = 2'd1,
        ROT2 = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int OP_P0 = 0;
    localparam int OP_P1 = 1;

    localparam logic [4:0] K1_P0 = 5'd9;
    localparam logic [4:0] K2_P0 = 5'd17;
    localparam logic [4:0] K1_P1 = 5'd15;
    localparam logic [4:0] K2_P1 = 5'd23;

    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] k);
        logic [63:0] w;
        w = {x, x} << k;
        return w[63:32];
    endfunction

endpackage

// File: rtl/frv_rol32.sv
// frv_rol32: combinational 32-bit left rotator.
module frv_rol32
    import frv_ssm3_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [4:0]  i_amt,
    output logic [31:0] o_data
);

    assign o_data = rol32(i_data, i_amt);

endmodule

// File: rtl/frv_ssm3_fu.sv
// frv_ssm3_fu: ssm3.p0/p1 execute unit; iterative datapath time-shares one rotator,
// FAST builds the whole permutation combinationally at accept.
module frv_ssm3_fu
    import frv_ssm3_pkg::*;
#(
    parameter bit FAST = 1'b0
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_rs1,
    input  logic [4:0]  req_rd,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [4:0]  rsp_rd
);

    state_t      r_state, w_next;
    logic [31:0] r_rs1, r_acc, w_rot, w_fast;
    logic [4:0]  r_rd, w_amt;
    logic        r_p0, w_accept, w_fp0;

    assign req_ready  = r_state == IDLE;
    assign rsp_valid  = r_state == DONE;
    assign rsp_rd     = r_rd;
    assign rsp_result = (r_rd == 5'd0) ? 32'd0 : r_acc;
    assign w_accept   = req_valid & ~flush & req_ready;

    assign w_amt = (r_state == ROT1) ? (r_p0 ? K1_P0 : K1_P1) : (r_p0 ? K2_P0 : K2_P1);

    frv_rol32 u_rol (
        .i_data (r_rs1),
        .i_amt  (w_amt),
        .o_data (w_rot)
    );

    assign w_fp0  = req_op[OP_P0];
    assign w_fast = req_rs1 ^ rol32(req_rs1, w_fp0 ? K1_P0 : K1_P1)
                            ^ rol32(req_rs1, w_fp0 ? K2_P0 : K2_P1);

    always_comb begin
        w_next = r_state;
        if (flush)
            w_next = IDLE;
        else
            case (r_state)
                IDLE: if (req_valid) w_next = FAST ? DONE : ROT1;
                ROT1: w_next = ROT2;
                ROT2: w_next = DONE;
                DONE: if (rsp_ready) w_next = IDLE;
            endcase
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_state <= IDLE;
            r_rs1   <= '0;
            r_acc   <= '0;
            r_rd    <= '0;
            r_p0    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_rs1 <= req_rs1;
                r_p0  <= w_fp0;
                r_rd  <= req_rd;
                r_acc <= FAST ? w_fast : req_rs1;
            end else if (r_state == ROT1 || r_state == ROT2) begin
                r_acc <= r_acc ^ w_rot;
            end
        end
    end

endmodule

// File: tb/tb_frv_ssm3_fu.sv
// tb_frv_ssm3_fu: randomized and directed checks of both datapath variants against a reference model.
module tb_frv_ssm3_fu;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b01;
    logic [31:0] req_rs1 = '0;
    logic [4:0]  req_rd = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_rd;

    logic        f_req_valid = 1'b0;
    logic        f_req_ready;
    logic [1:0]  f_req_op = 2'b01;
    logic [31:0] f_req_rs1 = '0;
    logic [4:0]  f_req_rd = '0;
    logic        f_rsp_valid;
    logic        f_rsp_ready = 1'b1;
    logic [31:0] f_rsp_result;
    logic [4:0]  f_rsp_rd;

    int checks = 0;
    int errors = 0;

    always #5 g_clk = ~g_clk;

    frv_ssm3_fu #(.FAST(1'b0)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rd(req_rd), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_rd(rsp_rd)
    );

    frv_ssm3_fu #(.FAST(1'b1)) dut_fast (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(1'b0),
        .req_valid(f_req_valid), .req_ready(f_req_ready), .req_op(f_req_op),
        .req_rs1(f_req_rs1), .req_rd(f_req_rd), .rsp_valid(f_rsp_valid),
        .rsp_ready(f_rsp_ready), .rsp_result(f_rsp_result), .rsp_rd(f_rsp_rd)
    );

    function automatic logic [31:0] rl(input logic [31:0] x, input int k);
        return (x << k) | (x >> (32 - k));
    endfunction

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] x, input logic [4:0] rd);
        if (rd == 5'd0) return 32'd0;
        return op[0] ? (x ^ rl(x, 9) ^ rl(x, 17)) : (x ^ rl(x, 15) ^ rl(x, 23));
    endfunction

    task automatic test_reset();
        #1 g_resetn = 1'b0;
        #2;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_rd !== 5'd0) begin
            errors++;
            $display("FAIL reset_slow: got ready=%b valid=%b res=%h rd=%0d want 1 0 0 0", req_ready, rsp_valid, rsp_result, rsp_rd);
        end
        checks++;
        if (f_req_ready !== 1'b1 || f_rsp_valid !== 1'b0 || f_rsp_result !== 32'd0 || f_rsp_rd !== 5'd0) begin
            errors++;
            $display("FAIL reset_fast: got ready=%b valid=%b res=%h rd=%0d want 1 0 0 0", f_req_ready, f_rsp_valid, f_rsp_result, f_rsp_rd);
        end
        repeat (2) @(negedge g_clk);
        g_resetn = 1'b1;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] x, input logic [4:0] rd, input string nm);
        int lat;
        logic [31:0] exp;
        exp = model(op, x, rd);
        @(negedge g_clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: got %b want 1", nm, req_ready);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_op = op;
        req_rs1 = x;
        req_rd = rd;
        @(negedge g_clk);
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 10) begin
            @(negedge g_clk);
            lat++;
        end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL %s_latency: got %0d want 3", nm, lat);
        end
        checks++;
        if (rsp_result !== exp || rsp_rd !== rd) begin
            errors++;
            $display("FAIL %s_result: got %h rd %0d want %h rd %0d", nm, rsp_result, rsp_rd, exp, rd);
        end
        @(negedge g_clk);
    endtask

    task automatic test_vectors();
        run_op(2'b01, 32'h0000_0001, 5'd5, "p0_one");
        run_op(2'b10, 32'h0000_0001, 5'd3, "p1_one");
        run_op(2'b01, 32'h8000_0000, 5'd9, "p0_msb");
        run_op(2'b01, 32'hFFFF_FFFF, 5'd0, "p0_rd0");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++)
            run_op($urandom_range(0, 1) ? 2'b01 : 2'b10, $urandom, 5'($urandom_range(0, 31)), "rand");
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] x, exp;
        x = $urandom;
        exp = model(2'b10, x, 5'd7);
        @(negedge g_clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_op = 2'b10;
        req_rs1 = x;
        req_rd = 5'd7;
        @(negedge g_clk);
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 10) begin
            @(negedge g_clk);
            lat++;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_result !== exp || rsp_rd !== 5'd7) begin
                errors++;
                $display("FAIL hold_%0d: got valid=%b ready=%b res=%h rd=%0d want 1 0 %h 7", i, rsp_valid, req_ready, rsp_result, rsp_rd, exp);
            end
            @(negedge g_clk);
        end
        rsp_ready = 1'b1;
        @(negedge g_clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL release: got valid=%b ready=%b want 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_flush();
        int seen = 0;
        @(negedge g_clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_op = 2'b01;
        req_rs1 = $urandom;
        req_rd = 5'd4;
        @(negedge g_clk);
        req_valid = 1'b0;
        @(negedge g_clk);
        flush = 1'b1;
        req_valid = 1'b1;
        req_rs1 = $urandom;
        @(negedge g_clk);
        flush = 1'b0;
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle: got valid=%b ready=%b want 0 1", rsp_valid, req_ready);
        end
        repeat (5) begin
            @(negedge g_clk);
            if (rsp_valid === 1'b1 || req_ready !== 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_quiet: got %0d busy/valid cycles want 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        @(negedge g_clk);
        req_valid = 1'b1;
        req_op = 2'b01;
        req_rs1 = 32'h1234_5678;
        req_rd = 5'd6;
        @(negedge g_clk);
        req_valid = 1'b0;
        g_resetn = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_rd !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid: got ready=%b valid=%b res=%h rd=%0d want 1 0 0 0", req_ready, rsp_valid, rsp_result, rsp_rd);
        end
        @(negedge g_clk);
        g_resetn = 1'b1;
        repeat (6) begin
            @(negedge g_clk);
            if (rsp_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got %0d valid cycles want 0", seen);
        end
    endtask

    task automatic fast_op(input logic [1:0] op, input logic [31:0] x, input logic [4:0] rd, input string nm);
        int lat;
        logic [31:0] exp;
        exp = model(op, x, rd);
        @(negedge g_clk);
        f_req_valid = 1'b1;
        f_req_op = op;
        f_req_rs1 = x;
        f_req_rd = rd;
        @(negedge g_clk);
        f_req_valid = 1'b0;
        lat = 1;
        while (f_rsp_valid !== 1'b1 && lat < 10) begin
            @(negedge g_clk);
            lat++;
        end
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL %s_latency: got %0d want 1", nm, lat);
        end
        checks++;
        if (f_rsp_result !== exp || f_rsp_rd !== rd) begin
            errors++;
            $display("FAIL %s_result: got %h rd %0d want %h rd %0d", nm, f_rsp_result, f_rsp_rd, exp, rd);
        end
        @(negedge g_clk);
        checks++;
        if (f_rsp_valid !== 1'b0 || f_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle: got valid=%b ready=%b want 0 1", nm, f_rsp_valid, f_req_ready);
        end
    endtask

    task automatic test_fast();
        fast_op(2'b01, 32'h0000_0001, 5'd5, "fast_p0");
        for (int i = 0; i < 6; i++)
            fast_op($urandom_range(0, 1) ? 2'b01 : 2'b10, $urandom, 5'($urandom_range(1, 31)), "fast_rand");
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_fast();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frv_ssm3_fu.md
FRV_SSM3_FU -- requirements
Module: frv_ssm3_fu

Multi-cycle execute-stage functional unit for ssm3.p0 / ssm3.p1. It feeds retirement, so it is the unit whose results the SSM3 trace checker validates. One shared 32-bit rotator is used across cycles to save area.

Interface
REQ-001 Parameter FAST, default 0: 0 = iterative 3-cycle datapath; 1 = single-cycle combinational datapath, same handshake.
REQ-002 g_clk  in  1  clock; all state updates on rising edge.
REQ-003 g_resetn  in  1  reset, asynchronous assert, active-low.
REQ-004 flush  in  1  pipeline flush; aborts any in-flight operation.
REQ-005 req_valid  in  1  operation request.
REQ-006 req_ready  out  1  unit accepts request this cycle.
REQ-007 req_op  in  2  one-hot operation; [0] = p0, [1] = p1.
REQ-008 req_rs1  in  32  source operand.
REQ-009 req_rd  in  5  destination register address.
REQ-010 rsp_valid  out  1  result available.
REQ-011 rsp_ready  in  1  consumer accepts result.
REQ-012 rsp_result  out  32  computed result; zero when rsp_rd == 0.
REQ-013 rsp_rd  out  5  destination address of the result.

Function
REQ-014 p0 result SHALL be x ^ rol(x,9) ^ rol(x,17); p1 result SHALL be x ^ rol(x,15) ^ rol(x,23); rotations are 32-bit, left.
REQ-015 FSM states SHALL be IDLE, ROT1, ROT2, DONE; reset state IDLE.
REQ-016 IDLE: req_ready = 1; req_valid & !flush latches rs1, op and rd, sets acc = rs1, and moves to ROT1.
REQ-017 ROT1: acc ^= rol(rs1, k1) with k1 = 9 (p0) or 15 (p1); next state ROT2.
REQ-018 ROT2: acc ^= rol(rs1, k2) with k2 = 17 (p0) or 23 (p1); next state DONE.
REQ-019 DONE: rsp_valid = 1; on rsp_ready, go to IDLE.
REQ-020 Accept-to-rsp_valid latency SHALL be 3 cycles when FAST = 0 and 1 cycle when FAST = 1 (IDLE -> DONE directly).
REQ-021 req_ready SHALL be 1 only in IDLE; there is no accept in DONE, and no back-to-back overlap.
REQ-022 rsp_result, rsp_rd and rsp_valid SHALL hold stable while rsp_valid & !rsp_ready.
REQ-023 rsp_result SHALL be forced to 0 when the latched rd == 0.
REQ-024 flush in any state SHALL force IDLE next cycle with rsp_valid = 0; flush overrides a simultaneous req_valid or rsp_ready, and no result is delivered.
REQ-025 req_op == 2'b00 or 2'b11 SHALL NOT be presented; behaviour in that case is undefined, and the bench excludes it by assumption.
REQ-026 When req_op[0] is set, p0 rotation amounts SHALL be selected; otherwise p1 amounts.

Reset
REQ-027 While g_resetn = 0: state = IDLE, rsp_valid = 0, req_ready = 1, rsp_result = 0, rsp_rd = 0, and all internal registers 0.
REQ-028 Reset asserted mid-operation SHALL discard the operation immediately (asynchronously); no rsp_valid follows the deassertion of reset.

Structure
REQ-029 A shared package frv_ssm3_pkg SHALL hold the state enum, the op one-hot bit indices, and the rotation constants 9, 17, 15 and 23.
REQ-030 The rotator SHALL be sub-module frv_rol32 (32-bit data, 5-bit amount, combinational), instantiated once and time-shared across ROT1/ROT2.

Verification
REQ-031 p0, rs1 = 0x00000001, rd = 5, rsp_ready = 1 -> rsp_valid 3 cycles after accept, result 0x00020201, rsp_rd = 5.
REQ-032 p1, rs1 = 0x00000001 -> result 0x00808001; p0, rs1 = 0x80000000 -> result 0x80010100.
REQ-033 p0, rs1 = 0xFFFFFFFF, rd = 0 -> result 0x00000000.
REQ-034 rsp_ready held 0 for 4 cycles in DONE -> rsp_* stable throughout, req_ready = 0; release -> IDLE next cycle.
REQ-035 flush in ROT2 with req_valid = 1 in the same cycle -> IDLE next cycle, no rsp_valid, request not accepted.
REQ-036 g_resetn pulsed low in ROT1 -> outputs at reset values immediately, no rsp_valid afterwards; FAST = 1 repeat of REQ-031 -> 1-cycle latency, same result.
